// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and control width.
package alu_pkg;

  localparam int ALU_CTRL_W = 3;
  localparam int ALU_DATA_W = 32;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  // Encodings outside the enum produce a zero result with the zero flag set.
  function automatic logic is_defined_op(input logic [ALU_CTRL_W-1:0] ctrl);
    case (ctrl)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: is_defined_op = 1'b1;
      default:                                    is_defined_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU with zero and signed-overflow flags.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_DATA_W-1:0] a,
  input  logic [ALU_DATA_W-1:0] b,
  input  logic [ALU_CTRL_W-1:0] alu_control,
  output logic [ALU_DATA_W-1:0] result,
  output logic                  zero,
  output logic                  overflow
);

  logic [ALU_DATA_W-1:0] sum;
  logic [ALU_DATA_W-1:0] diff;
  logic                  lt_signed;

  assign sum       = a + b;
  assign diff      = a - b;
  assign lt_signed = $signed(a) < $signed(b);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_control)
      ALU_ADD: begin
        result   = sum;
        overflow = (a[ALU_DATA_W-1] == b[ALU_DATA_W-1]) &&
                   (sum[ALU_DATA_W-1] != a[ALU_DATA_W-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[ALU_DATA_W-1] != b[ALU_DATA_W-1]) &&
                   (diff[ALU_DATA_W-1] != a[ALU_DATA_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(ALU_DATA_W-1){1'b0}}, lt_signed};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner, cyclically.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               cand;

  // Pointer resets to the last index so requester 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDX_W'(N-1);
    end else if (advance) begin
      ptr <= idx;
    end
  end

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && req[IDX_W'(cand)]) begin
        gnt[IDX_W'(cand)] = 1'b1;
        idx               = IDX_W'(cand);
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU among N_REQ requesters; each requester owns a 1-deep response slot.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int CTRL_W = ALU_CTRL_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ*CTRL_W-1:0] req_ctrl,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [N_REQ*DATA_W-1:0] rsp_rslt,
  output logic [N_REQ-1:0]        rsp_zero,
  output logic [N_REQ-1:0]        rsp_ovf,
  output logic                    busy
);

  localparam int IDX_W = $clog2(N_REQ);

  if (DATA_W != ALU_DATA_W) begin : g_bad_data_w
    $error("alu_share_arb: DATA_W must be 32 to match alu");
  end
  if (CTRL_W != ALU_CTRL_W) begin : g_bad_ctrl_w
    $error("alu_share_arb: CTRL_W must be 3 to match alu");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("alu_share_arb: N_REQ must be in 2..8");
  end

  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              any_gnt;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] alu_rslt;
  logic              alu_zero;
  logic              alu_ovf;

  // A full slot being drained this cycle can accept a new result at the same edge.
  assign eligible = req_valid & (~rsp_valid | rsp_ready);
  assign any_gnt  = |gnt;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (eligible),
    .advance (any_gnt),
    .gnt     (gnt),
    .idx     (gnt_idx)
  );

  assign req_ready = gnt & {N_REQ{rst_n}};

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    if (any_gnt) begin
      alu_a    = req_a[int'(gnt_idx)*DATA_W +: DATA_W];
      alu_b    = req_b[int'(gnt_idx)*DATA_W +: DATA_W];
      alu_ctrl = req_ctrl[int'(gnt_idx)*CTRL_W +: CTRL_W];
    end
  end

  alu u_alu (
    .a           (alu_a),
    .b           (alu_b),
    .alu_control (alu_ctrl),
    .result      (alu_rslt),
    .zero        (alu_zero),
    .overflow    (alu_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_rslt  <= '0;
      rsp_zero  <= '0;
      rsp_ovf   <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i]) begin
          rsp_valid[i]                   <= 1'b1;
          rsp_rslt[i*DATA_W +: DATA_W]   <= alu_rslt;
          rsp_zero[i]                    <= alu_zero;
          rsp_ovf[i]                     <= alu_ovf;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign busy = (|req_valid) | (|rsp_valid);

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

  // A stalled requester must keep its operands stable until accepted or withdrawn.
  for (genvar g = 0; g < N_REQ; g++) begin : g_stable_chk
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[g] && !req_ready[g]) |=>
        (!req_valid[g] ||
         ($stable(req_a[g*DATA_W +: DATA_W]) &&
          $stable(req_b[g*DATA_W +: DATA_W]) &&
          $stable(req_ctrl[g*CTRL_W +: CTRL_W]))));
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed tables, corner sequences, random vs model.
module tb_alu_share_arb;

  localparam int N = 2;
  localparam int W = 32;
  localparam int C = 3;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*C-1:0] req_ctrl;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [N*W-1:0] rsp_rslt;
  logic [N-1:0]   rsp_zero;
  logic [N-1:0]   rsp_ovf;
  logic           busy;

  alu_share_arb #(.N_REQ(N), .DATA_W(W), .CTRL_W(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ctrl  (req_ctrl),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rslt  (rsp_rslt),
    .rsp_zero  (rsp_zero),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model state: one response slot per requester plus last winner.
  int          m_ptr;
  logic        m_val  [N];
  logic [31:0] m_rslt [N];
  logic        m_z    [N];
  logic        m_o    [N];
  int          cur_g;
  int          wait_cnt [N];
  int          max_wait;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rslt;
    logic        z;
    logic        o;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output logic o);
    longint sa;
    longint sb;
    longint s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    r  = 32'd0;
    o  = 1'b0;
    case (c)
      3'd0: begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd1: begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    z = (r == 32'd0);
  endfunction

  task automatic model_reset();
    m_ptr = N - 1;
    for (int i = 0; i < N; i++) begin
      m_val[i]    = 1'b0;
      m_rslt[i]   = 32'd0;
      m_z[i]      = 1'b0;
      m_o[i]      = 1'b0;
      wait_cnt[i] = 0;
    end
    cur_g = -1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] c,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]       = v;
    req_ctrl[i*C +: C] = c;
    req_a[i*W +: W]    = a;
    req_b[i*W +: W]    = b;
  endtask

  // Negative edge: derive the expected grant and compare every output with the model.
  task automatic at_neg();
    logic [N-1:0] elig;
    logic [N-1:0] exp_rdy;
    logic         any_v;
    @(negedge clk);
    cur_g = -1;
    for (int i = 0; i < N; i++) elig[i] = req_valid[i] && (!m_val[i] || rsp_ready[i]);
    for (int k = 1; k <= N; k++) begin
      if (cur_g < 0 && elig[(m_ptr + k) % N]) cur_g = (m_ptr + k) % N;
    end
    exp_rdy = '0;
    if (cur_g >= 0) exp_rdy[cur_g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    any_v = 1'b0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'(m_val[i]));
      check($sformatf("rsp_rslt[%0d]", i), 64'(rsp_rslt[i*W +: W]), 64'(m_rslt[i]));
      check($sformatf("rsp_zero[%0d]", i), 64'(rsp_zero[i]), 64'(m_z[i]));
      check($sformatf("rsp_ovf[%0d]", i), 64'(rsp_ovf[i]), 64'(m_o[i]));
      any_v = any_v | m_val[i] | req_valid[i];
      if (elig[i] && cur_g != i) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
    check("busy", 64'(busy), 64'(any_v));
  endtask

  // Positive edge: commit the model with the inputs the DUT saw at this edge.
  task automatic at_pos();
    logic [31:0] r;
    logic        z;
    logic        o;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (i == cur_g) begin
        ref_alu(req_ctrl[i*C +: C], req_a[i*W +: W], req_b[i*W +: W], r, z, o);
        m_val[i]  = 1'b1;
        m_rslt[i] = r;
        m_z[i]    = z;
        m_o[i]    = o;
      end else if (rsp_ready[i]) begin
        m_val[i] = 1'b0;
      end
    end
    if (cur_g >= 0) m_ptr = cur_g;
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: rand_operand = 32'h0000_0000;
      1: rand_operand = 32'h0000_0001;
      2: rand_operand = 32'h7FFF_FFFF;
      3: rand_operand = 32'h8000_0000;
      4: rand_operand = 32'hFFFF_FFFF;
      default: rand_operand = $urandom();
    endcase
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    max_wait    = 0;
    rst_n       = 1'b1;
    req_valid   = '0;
    rsp_ready   = '0;
    req_a       = '0;
    req_b       = '0;
    req_ctrl    = '0;
    model_reset();

    tbl[0]  = '{3'b001, 32'd5,          32'd7,          32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[1]  = '{3'b101, 32'hFFFF_FFFF, 32'd1,          32'd1,         1'b0, 1'b0};
    tbl[2]  = '{3'b010, 32'h0000_00F0, 32'h0000_000F, 32'd0,         1'b1, 1'b0};
    tbl[3]  = '{3'b110, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0,         1'b1, 1'b0};
    tbl[4]  = '{3'b000, 32'h7FFF_FFFF, 32'd1,          32'h8000_0000, 1'b0, 1'b1};
    tbl[5]  = '{3'b001, 32'h8000_0000, 32'd1,          32'h7FFF_FFFF, 1'b0, 1'b1};
    tbl[6]  = '{3'b011, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0};
    tbl[7]  = '{3'b000, 32'hFFFF_FFFF, 32'd1,          32'd0,         1'b1, 1'b0};
    tbl[8]  = '{3'b101, 32'd1,          32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0};
    tbl[9]  = '{3'b100, 32'd9,          32'd3,          32'd0,         1'b1, 1'b0};
    tbl[10] = '{3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0};
    tbl[11] = '{3'b000, 32'd100,        32'd23,         32'd123,       1'b0, 1'b0};

    // Reset state.
    #1 rst_n = 1'b0;
    #2;
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check("reset_rsp_rslt", 64'(rsp_rslt), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Table: one op at a time, alternating requesters.
    for (int t = 0; t < 12; t++) begin
      int r;
      r = t % 2;
      rsp_ready = '1;
      req_valid = '0;
      set_req(r, 1'b1, tbl[t].ctrl, tbl[t].a, tbl[t].b);
      at_neg();
      check($sformatf("tbl%0d_ready", t), 64'(req_ready), 64'(1 << r));
      at_pos();
      req_valid = '0;
      at_neg();
      check($sformatf("tbl%0d_valid", t), 64'(rsp_valid[r]), 64'(1));
      check($sformatf("tbl%0d_rslt", t), 64'(rsp_rslt[r*W +: W]), 64'(tbl[t].rslt));
      check($sformatf("tbl%0d_zero", t), 64'(rsp_zero[r]), 64'(tbl[t].z));
      check($sformatf("tbl%0d_ovf", t), 64'(rsp_ovf[r]), 64'(tbl[t].o));
      at_pos();
    end

    // Reset mid-traffic with both slots full.
    req_valid = '0;
    rsp_ready = '0;
    at_neg();
    at_pos();
    set_req(0, 1'b1, 3'b000, 32'd1, 32'd2);
    set_req(1, 1'b1, 3'b011, 32'd4, 32'd8);
    at_neg();
    at_pos();
    at_neg();
    at_pos();
    at_neg();
    check("pre_reset_valid", 64'(rsp_valid), 64'(2'b11));
    at_pos();
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_valid", 64'(rsp_valid), 64'(0));
    check("mid_reset_rslt", 64'(rsp_rslt), 64'(0));
    check("mid_reset_zero", 64'(rsp_zero), 64'(0));
    check("mid_reset_ready", 64'(req_ready), 64'(0));
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    at_neg();
    check("post_reset_tie", 64'(req_ready), 64'(2'b01));
    at_pos();

    // Round-robin alternation, overflow on requester 1.
    do_reset();
    rsp_ready = 2'b11;
    set_req(0, 1'b1, 3'b010, 32'hFF, 32'h0F);
    set_req(1, 1'b1, 3'b000, 32'h7FFF_FFFF, 32'd1);
    for (int k = 0; k < 4; k++) begin
      at_neg();
      check($sformatf("rr_grant%0d", k), 64'(req_ready), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
      if (k >= 2) begin
        check($sformatf("rr_ovf1_%0d", k), 64'(rsp_ovf[1]), 64'(1));
        check($sformatf("rr_rslt1_%0d", k), 64'(rsp_rslt[W +: W]), 64'(32'h8000_0000));
      end
      at_pos();
    end

    // Backpressure on slot 0 while requester 1 keeps flowing.
    do_reset();
    rsp_ready = 2'b00;
    req_valid = '0;
    set_req(0, 1'b1, 3'b001, 32'd10, 32'd3);
    at_neg();
    check("bp_fill", 64'(req_ready), 64'(2'b01));
    at_pos();
    set_req(0, 1'b1, 3'b000, 32'd100, 32'd23);
    set_req(1, 1'b1, 3'b011, 32'd1, 32'd2);
    rsp_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      check($sformatf("bp_stall%0d", k), 64'(req_ready), 64'(2'b10));
      check($sformatf("bp_hold%0d", k), 64'(rsp_rslt[0 +: W]), 64'(32'd7));
      at_pos();
    end
    rsp_ready = 2'b11;
    at_neg();
    check("bp_release", 64'(req_ready), 64'(2'b01));
    at_pos();
    req_valid = '0;
    at_neg();
    check("bp_reload", 64'(rsp_rslt[0 +: W]), 64'(32'd123));
    at_pos();

    // Random traffic against the model.
    do_reset();
    max_wait = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && cur_g != i) begin
          if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
        end else begin
          set_req(i, ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  rand_operand(), rand_operand());
        end
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      at_neg();
      at_pos();
    end
    check("starvation_bound", 64'(max_wait > N), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
